// File: rtl/control_unit.sv
// Multi-cycle control FSM: sequences the IR word over steps T0..T3.
// Ports: Clock/Reset/Run/IR in; datapath enables, ALUop, Done, Tstep out.
module control_unit #(
  parameter int n    = 10,
  parameter int NREG = 8
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Run,
  input  logic [n-1:0]    IR,
  output logic            IRin,
  output logic [NREG-1:0] Rin,
  output logic [NREG-1:0] Rout,
  output logic            Ain,
  output logic            Gin,
  output logic            Gout,
  output logic            DINout,
  output logic [1:0]      ALUop,
  output logic            ADDRin,
  output logic            DOUTin,
  output logic            W_D,
  output logic            Done,
  output logic [1:0]      Tstep
);

  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  logic [3:0]      op;
  logic [NREG-1:0] xsel;
  logic [NREG-1:0] ysel;
  logic [1:0]      alu_code;
  logic            is_mv;
  logic            is_mvi;
  logic            is_alu;
  logic            is_ld;
  logic            is_st;
  logic            is_nop;

  assign op   = IR[n-1:n-4];
  assign xsel = NREG'(1) << IR[5:3];
  assign ysel = NREG'(1) << IR[2:0];

  // add/sub/and/slt are opcodes 2..5; flipping bit 1
  // maps them onto ALU codes 0..3.
  assign alu_code = op[1:0] ^ 2'b10;

  // Opcode classes are mutually exclusive and cover
  // all 16 encodings (1xxx is NOP).
  assign is_nop = op[3];
  assign is_mv  = (op == 4'd0);
  assign is_mvi = (op == 4'd1);
  assign is_alu = !op[3] && (op[2:1] == 2'b01 ||
                             op[2:1] == 2'b10);
  assign is_ld  = (op == 4'd6);
  assign is_st  = (op == 4'd7);

  always_comb begin
    IRin   = 1'b0;
    Rin    = '0;
    Rout   = '0;
    Ain    = 1'b0;
    Gin    = 1'b0;
    Gout   = 1'b0;
    DINout = 1'b0;
    ALUop  = 2'b00;
    ADDRin = 1'b0;
    DOUTin = 1'b0;
    W_D    = 1'b0;
    Done   = 1'b0;
    unique case (Tstep)
      T0: IRin = Run;
      T1: begin
        unique case (1'b1)
          is_mv: begin
            Rout = ysel;
            Rin  = xsel;
            Done = 1'b1;
          end
          is_mvi: begin
            DINout = 1'b1;
            Rin    = xsel;
            Done   = 1'b1;
          end
          is_alu: begin
            Rout = xsel;
            Ain  = 1'b1;
          end
          is_ld, is_st: begin
            Rout   = ysel;
            ADDRin = 1'b1;
          end
          is_nop: Done = 1'b1;
        endcase
      end
      T2: begin
        unique case (1'b1)
          is_alu: begin
            Rout  = ysel;
            Gin   = 1'b1;
            ALUop = alu_code;
          end
          is_ld: ;
          is_st: begin
            Rout   = xsel;
            DOUTin = 1'b1;
            W_D    = 1'b1;
            Done   = 1'b1;
          end
          // Unreachable for other ops; end the
          // instruction rather than wander.
          default: Done = 1'b1;
        endcase
      end
      T3: begin
        unique case (1'b1)
          is_alu: begin
            Gout = 1'b1;
            Rin  = xsel;
            Done = 1'b1;
          end
          is_ld: begin
            DINout = 1'b1;
            Rin    = xsel;
            Done   = 1'b1;
          end
          default: Done = 1'b1;
        endcase
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset)
      Tstep <= T0;
    else if (Done)
      Tstep <= T0;
    else if (Tstep == T0 && !Run)
      Tstep <= T0;
    else
      Tstep <= Tstep + 2'd1;
  end

endmodule
